// File: rtl/wb_unaligned_bridge_pkg.sv
// Shared types and constants for the unaligned Wishbone bridge: FSM states,
// lane-select encodings and the latched CPU request.
package wb_unaligned_bridge_pkg;

  localparam int unsigned ADR_W      = 20;
  localparam int unsigned WADR_W     = 19;
  localparam int unsigned DAT_W      = 16;
  localparam int unsigned SEL_W_BITS = 2;
  localparam int unsigned WAIT_W     = 16;
  localparam int unsigned WAIT_LIMIT_DEF = 16;

  localparam logic [SEL_W_BITS-1:0] SEL_LO = 2'b01;
  localparam logic [SEL_W_BITS-1:0] SEL_HI = 2'b10;
  localparam logic [SEL_W_BITS-1:0] SEL_W  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CYC1 = 2'd1,
    ST_CYC2 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic             byte_op;
    logic             we;
    logic [DAT_W-1:0] dat;
  } cpu_req_t;

endpackage

// File: rtl/wb_unaligned_bridge_if.sv
// CPU-side request channel and Wishbone master channel of the bridge.
// Signal suffixes are relative to the bridge.
interface wb_unaligned_bridge_if;
  import wb_unaligned_bridge_pkg::*;

  logic                  cpu_req_i;
  logic [ADR_W-1:0]      cpu_adr_i;
  logic                  cpu_byte_i;
  logic                  cpu_we_i;
  logic [DAT_W-1:0]      cpu_dat_i;
  logic [DAT_W-1:0]      cpu_dat_o;
  logic                  cpu_ack_o;
  logic                  cpu_err_o;

  logic [WADR_W-1:0]     wbm_adr_o;
  logic [DAT_W-1:0]      wbm_dat_o;
  logic [DAT_W-1:0]      wbm_dat_i;
  logic [SEL_W_BITS-1:0] wbm_sel_o;
  logic                  wbm_we_o;
  logic                  wbm_stb_o;
  logic                  wbm_cyc_o;
  logic                  wbm_ack_i;

  modport master (
    input  cpu_req_i, cpu_adr_i, cpu_byte_i, cpu_we_i, cpu_dat_i,
    output cpu_dat_o, cpu_ack_o, cpu_err_o,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cpu_req_i, cpu_adr_i, cpu_byte_i, cpu_we_i, cpu_dat_i,
    input  cpu_dat_o, cpu_ack_o, cpu_err_o,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/wb_unaligned_bridge_lane_steer.sv
// Byte-lane steering: maps address parity, op size and split phase onto the
// Wishbone lane selects and write data. Unselected lanes drive zero.
module wb_lane_steer
  import wb_unaligned_bridge_pkg::*;
(
  input  logic                  adr0_i,
  input  logic                  byte_i,
  input  logic                  phase_i,
  input  logic [DAT_W-1:0]      dat_i,
  output logic [SEL_W_BITS-1:0] sel_c_o,
  output logic [DAT_W-1:0]      dat_c_o
);

  always_comb begin
    sel_c_o = SEL_W;
    dat_c_o = dat_i;
    if (byte_i) begin
      sel_c_o = adr0_i ? SEL_HI : SEL_LO;
      dat_c_o = adr0_i ? {dat_i[7:0], 8'h00} : {8'h00, dat_i[7:0]};
    end else if (adr0_i) begin
      // Odd word: low CPU byte goes out first on the high lane.
      sel_c_o = phase_i ? SEL_LO : SEL_HI;
      dat_c_o = phase_i ? {8'h00, dat_i[15:8]} : {dat_i[7:0], 8'h00};
    end
  end

endmodule

// File: rtl/wb_unaligned_bridge.sv
// Wishbone master bridge from byte-addressed CPU requests to a 16-bit
// word-addressed slave; splits odd word accesses and reassembles read data.
module wb_unaligned_bridge
  import wb_unaligned_bridge_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_unaligned_bridge_if.master bus
);

  state_e                state_q, state_d;
  cpu_req_t              req_q, req_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [DAT_W-1:0]      cpu_dat_q, cpu_dat_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  cpu_err_q, cpu_err_d;
  logic [WADR_W-1:0]     wbm_adr_q, wbm_adr_d;
  logic [DAT_W-1:0]      wbm_dat_q, wbm_dat_d;
  logic [SEL_W_BITS-1:0] wbm_sel_q, wbm_sel_d;
  logic                  wbm_we_q, wbm_we_d;
  logic                  wbm_cyc_q, wbm_cyc_d;

  logic                  st_adr0_c, st_byte_c, st_phase_c;
  logic [DAT_W-1:0]      st_dat_c;
  logic [SEL_W_BITS-1:0] st_sel_c;
  logic [DAT_W-1:0]      st_wdat_c;
  logic                  split_c, timeout_c;

  // Steering sees live CPU inputs when launching CYC1, latched request for CYC2.
  always_comb begin
    st_adr0_c  = (state_q == ST_IDLE) ? bus.cpu_adr_i[0] : req_q.adr[0];
    st_byte_c  = (state_q == ST_IDLE) ? bus.cpu_byte_i   : req_q.byte_op;
    st_dat_c   = (state_q == ST_IDLE) ? bus.cpu_dat_i    : req_q.dat;
    st_phase_c = (state_q != ST_IDLE);
  end

  wb_lane_steer u_steer (
    .adr0_i  (st_adr0_c),
    .byte_i  (st_byte_c),
    .phase_i (st_phase_c),
    .dat_i   (st_dat_c),
    .sel_c_o (st_sel_c),
    .dat_c_o (st_wdat_c)
  );

  assign split_c   = ~req_q.byte_op & req_q.adr[0];
  assign timeout_c = (WAIT_LIMIT != 32'd0) && ((32'(wait_q) + 32'd1) == WAIT_LIMIT);

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wait_d    = wait_q;
    cpu_dat_d = cpu_dat_q;
    cpu_ack_d = 1'b0;
    cpu_err_d = 1'b0;
    wbm_adr_d = wbm_adr_q;
    wbm_dat_d = wbm_dat_q;
    wbm_sel_d = wbm_sel_q;
    wbm_we_d  = wbm_we_q;
    wbm_cyc_d = wbm_cyc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req_i) begin
          req_d     = '{adr: bus.cpu_adr_i, byte_op: bus.cpu_byte_i,
                        we: bus.cpu_we_i, dat: bus.cpu_dat_i};
          state_d   = ST_CYC1;
          wait_d    = '0;
          wbm_adr_d = bus.cpu_adr_i[ADR_W-1:1];
          wbm_sel_d = st_sel_c;
          wbm_dat_d = st_wdat_c;
          wbm_we_d  = bus.cpu_we_i;
          wbm_cyc_d = 1'b1;
        end
      end
      ST_CYC1: begin
        if (bus.wbm_ack_i) begin
          if (req_q.byte_op) begin
            cpu_dat_d = {8'h00, req_q.adr[0] ? bus.wbm_dat_i[15:8] : bus.wbm_dat_i[7:0]};
          end else if (req_q.adr[0]) begin
            cpu_dat_d[7:0] = bus.wbm_dat_i[15:8];
          end else begin
            cpu_dat_d = bus.wbm_dat_i;
          end
          if (split_c) begin
            // cyc/stb stay up across the split; only address, lanes and data move.
            state_d   = ST_CYC2;
            wait_d    = '0;
            wbm_adr_d = req_q.adr[ADR_W-1:1] + 19'd1;
            wbm_sel_d = st_sel_c;
            wbm_dat_d = st_wdat_c;
          end else begin
            state_d   = ST_DONE;
            wbm_cyc_d = 1'b0;
            cpu_ack_d = 1'b1;
          end
        end else if (timeout_c) begin
          state_d   = ST_DONE;
          wbm_cyc_d = 1'b0;
          cpu_ack_d = 1'b1;
          cpu_err_d = 1'b1;
          cpu_dat_d = 16'hFFFF;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_CYC2: begin
        if (bus.wbm_ack_i) begin
          cpu_dat_d[15:8] = bus.wbm_dat_i[7:0];
          state_d   = ST_DONE;
          wbm_cyc_d = 1'b0;
          cpu_ack_d = 1'b1;
        end else if (timeout_c) begin
          state_d   = ST_DONE;
          wbm_cyc_d = 1'b0;
          cpu_ack_d = 1'b1;
          cpu_err_d = 1'b1;
          cpu_dat_d = 16'hFFFF;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      wait_q    <= '0;
      cpu_dat_q <= '0;
      cpu_ack_q <= 1'b0;
      cpu_err_q <= 1'b0;
      wbm_adr_q <= '0;
      wbm_dat_q <= '0;
      wbm_sel_q <= '0;
      wbm_we_q  <= 1'b0;
      wbm_cyc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wait_q    <= wait_d;
      cpu_dat_q <= cpu_dat_d;
      cpu_ack_q <= cpu_ack_d;
      cpu_err_q <= cpu_err_d;
      wbm_adr_q <= wbm_adr_d;
      wbm_dat_q <= wbm_dat_d;
      wbm_sel_q <= wbm_sel_d;
      wbm_we_q  <= wbm_we_d;
      wbm_cyc_q <= wbm_cyc_d;
    end
  end

  assign bus.cpu_dat_o = cpu_dat_q;
  assign bus.cpu_ack_o = cpu_ack_q;
  assign bus.cpu_err_o = cpu_err_q;
  assign bus.wbm_adr_o = wbm_adr_q;
  assign bus.wbm_dat_o = wbm_dat_q;
  assign bus.wbm_sel_o = wbm_sel_q;
  assign bus.wbm_we_o  = wbm_we_q;
  assign bus.wbm_stb_o = wbm_cyc_q;
  assign bus.wbm_cyc_o = wbm_cyc_q;

endmodule
